// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: default widths, grant encoding
// and the bit positions of the per-port starvation flags.
package dmem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_P1   = 2'd2,
    GNT_P2   = 2'd3
  } gnt_e;

  // Also used as the request/grant bit index of each peripheral port
  localparam int STARVED_P1 = 0;
  localparam int STARVED_P2 = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU, the display/event peripherals, the data RAM and
// the arbiter. The arbiter takes the slave view, the surroundings the master view.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA;
  logic          CPU_WE;
  logic          CPU_RE;
  logic [DW-1:0] CPU_RDATA;

  logic          P1_VALID;
  logic [AW-1:0] P1_ADDR;
  logic          P1_READY;
  logic          P1_RVALID;
  logic [DW-1:0] P1_RDATA;

  logic          P2_VALID;
  logic [AW-1:0] P2_ADDR;
  logic [DW-1:0] P2_WDATA;
  logic          P2_READY;

  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic          MEM_WE;
  logic [DW-1:0] MEM_RDATA;

  logic [1:0]    STARVED;

  modport slave (
    input  CPU_ADDR, CPU_WDATA, CPU_WE, CPU_RE,
    input  P1_VALID, P1_ADDR,
    input  P2_VALID, P2_ADDR, P2_WDATA,
    input  MEM_RDATA,
    output CPU_RDATA, P1_READY, P1_RVALID, P1_RDATA, P2_READY,
    output MEM_ADDR, MEM_WDATA, MEM_WE, STARVED
  );

  modport master (
    output CPU_ADDR, CPU_WDATA, CPU_WE, CPU_RE,
    output P1_VALID, P1_ADDR,
    output P2_VALID, P2_ADDR, P2_WDATA,
    output MEM_RDATA,
    input  CPU_RDATA, P1_READY, P1_RVALID, P1_RDATA, P2_READY,
    input  MEM_ADDR, MEM_WDATA, MEM_WE, STARVED
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted most recently
// wins. The last-grant flop only moves when a grant is actually issued.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req_i,
  input  logic       inhibit_i,
  output logic [1:0] gnt_o
);

  // 0: requester 0 granted last, 1: requester 1 granted last
  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (!inhibit_i) begin
      if (req_i[0] && (!req_i[1] || last_q)) begin
        gnt_o[0] = 1'b1;
      end else if (req_i[1]) begin
        gnt_o[1] = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = 1'b0;
    end else if (gnt_o[1]) begin
      last_d = 1'b1;
    end
  end

  // Reset to "requester 1 last" so requester 0 wins the first tie
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: the CPU owns the RAM whenever it loads or stores; the display
// reader (P1) and event writer (P2) share idle cycles round-robin.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 64
) (
  input  logic           CLK,
  input  logic           RESET,
  dmem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          cpu_act;
  logic [1:0]    port_valid;
  logic [1:0]    rr_gnt;
  logic [1:0]    starved;
  gnt_e          grant;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          p1_rvalid_q;
  logic [DW-1:0] p1_rdata_q;

  assign cpu_act = bus.CPU_WE | bus.CPU_RE;

  assign port_valid[STARVED_P1] = bus.P1_VALID;
  assign port_valid[STARVED_P2] = bus.P2_VALID;

  // Reset inhibits the peripherals so nothing fires while it is held
  rr_arb2 u_rr (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_i     (port_valid),
    .inhibit_i (cpu_act | RESET),
    .gnt_o     (rr_gnt)
  );

  always_comb begin
    grant = GNT_NONE;
    if (cpu_act) begin
      grant = GNT_CPU;
    end else if (rr_gnt[STARVED_P1]) begin
      grant = GNT_P1;
    end else if (rr_gnt[STARVED_P2]) begin
      grant = GNT_P2;
    end
  end

  always_comb begin
    mem_addr  = bus.CPU_ADDR;
    mem_wdata = bus.CPU_WDATA;
    mem_we    = 1'b0;
    case (grant)
      GNT_CPU: mem_we = bus.CPU_WE;
      GNT_P1:  mem_addr = bus.P1_ADDR;
      GNT_P2: begin
        mem_addr  = bus.P2_ADDR;
        mem_wdata = bus.P2_WDATA;
        mem_we    = 1'b1;
      end
      default: ;
    endcase
    // A CPU store presented during reset must not reach the RAM
    if (RESET) begin
      mem_we = 1'b0;
    end
  end

  assign bus.MEM_ADDR  = mem_addr;
  assign bus.MEM_WDATA = mem_wdata;
  assign bus.MEM_WE    = mem_we;
  assign bus.CPU_RDATA = bus.MEM_RDATA;
  assign bus.P1_READY  = rr_gnt[STARVED_P1];
  assign bus.P2_READY  = rr_gnt[STARVED_P2];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      p1_rvalid_q <= 1'b0;
      p1_rdata_q  <= '0;
    end else begin
      p1_rvalid_q <= rr_gnt[STARVED_P1];
      if (rr_gnt[STARVED_P1]) begin
        p1_rdata_q <= bus.MEM_RDATA;
      end
    end
  end

  assign bus.P1_RVALID = p1_rvalid_q;
  assign bus.P1_RDATA  = p1_rdata_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_starve
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          starved_q;
      logic          starved_d;

      always_comb begin
        cnt_d = cnt_q;
        if (!port_valid[gi] || rr_gnt[gi]) begin
          cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
          cnt_d = cnt_q + CW'(1);
        end
        starved_d = starved_q | (cnt_d == LIMIT);
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          cnt_q     <= '0;
          starved_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          starved_q <= starved_d;
        end
      end

      assign starved[gi] = starved_q;
    end
  endgenerate

  assign bus.STARVED = starved;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus
// hand sequences for starvation, reset during a fire and the first tie after reset.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

  dmem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(64)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // RAM model with a bench-side preload port
  logic [7:0] ram [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00;
  logic [7:0] ld_data = 8'h00;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (bus.MEM_WE) ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
  end
  assign bus.MEM_RDATA = ram[bus.MEM_ADDR];

  // Protocol guard: a requester may not drop VALID before it has seen READY
  logic pend1 = 1'b0;
  logic pend2 = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(pend1 && !bus.P1_VALID)) else $error("P1 dropped VALID before READY");
      assert (!(pend2 && !bus.P2_VALID)) else $error("P2 dropped VALID before READY");
    end
    pend1 <= !rst && bus.P1_VALID && !bus.P1_READY;
    pend2 <= !rst && bus.P2_VALID && !bus.P2_READY;
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic       we, re;
    logic [7:0] caddr, cwd;
    logic       v1;
    logic [7:0] a1;
    logic       v2;
    logic [7:0] a2, d2;
    logic       r1, r2, mwe;
    logic [7:0] madr, mwd, crd;
    logic       rv;
    logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(
    input logic we, re, input logic [7:0] caddr, cwd,
    input logic v1, input logic [7:0] a1,
    input logic v2, input logic [7:0] a2, d2,
    input logic r1, r2, mwe, input logic [7:0] madr, mwd, crd,
    input logic rv, input logic [7:0] rd);
    vec_t v;
    v.we = we; v.re = re; v.caddr = caddr; v.cwd = cwd;
    v.v1 = v1; v.a1 = a1; v.v2 = v2; v.a2 = a2; v.d2 = d2;
    v.r1 = r1; v.r2 = r2; v.mwe = mwe; v.madr = madr; v.mwd = mwd; v.crd = crd;
    v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic drive(input logic we, re, input logic [7:0] caddr, cwd,
                       input logic v1, input logic [7:0] a1,
                       input logic v2, input logic [7:0] a2, d2);
    bus.CPU_WE = we; bus.CPU_RE = re; bus.CPU_ADDR = caddr; bus.CPU_WDATA = cwd;
    bus.P1_VALID = v1; bus.P1_ADDR = a1;
    bus.P2_VALID = v2; bus.P2_ADDR = a2; bus.P2_WDATA = d2;
  endtask

  vec_t vec [18];
  logic [7:0] pre_a [5];
  logic [7:0] pre_d [5];

  initial begin
    //            we re caddr cwd  v1 a1    v2 a2    d2    r1 r2 mwe madr  mwd   crd   rv rd
    vec[0]  = mk(0, 0, 8'h00, 8'h00, 1, 8'h10, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 8'h3C, 0, 8'h00);
    vec[1]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h3C);
    vec[2]  = mk(1, 0, 8'h20, 8'h55, 0, 8'h00, 1, 8'h30, 8'h99, 0, 0, 1, 8'h20, 8'h55, 8'h00, 0, 8'h3C);
    vec[3]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h30, 8'h99, 0, 1, 1, 8'h30, 8'h99, 8'h00, 0, 8'h3C);
    vec[4]  = mk(0, 1, 8'h20, 8'h00, 1, 8'h11, 0, 8'h00, 8'h00, 0, 0, 0, 8'h20, 8'h00, 8'h55, 0, 8'h3C);
    vec[5]  = mk(0, 1, 8'h30, 8'h00, 1, 8'h11, 0, 8'h00, 8'h00, 0, 0, 0, 8'h30, 8'h00, 8'h99, 0, 8'h3C);
    vec[6]  = mk(0, 0, 8'h00, 8'h00, 1, 8'h11, 1, 8'h40, 8'h77, 1, 0, 0, 8'h11, 8'h00, 8'h5A, 0, 8'h3C);
    vec[7]  = mk(0, 0, 8'h00, 8'h00, 1, 8'h12, 1, 8'h40, 8'h77, 0, 1, 1, 8'h40, 8'h77, 8'h00, 1, 8'h5A);
    vec[8]  = mk(0, 0, 8'h00, 8'h00, 1, 8'h12, 1, 8'h41, 8'h88, 1, 0, 0, 8'h12, 8'h00, 8'hC3, 0, 8'h5A);
    vec[9]  = mk(0, 0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h41, 8'h88, 0, 1, 1, 8'h41, 8'h88, 8'h00, 1, 8'hC3);
    vec[10] = mk(0, 0, 8'h00, 8'h00, 1, 8'h10, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 8'h3C, 0, 8'hC3);
    vec[11] = mk(0, 0, 8'h00, 8'h00, 1, 8'h05, 0, 8'h00, 8'h00, 1, 0, 0, 8'h05, 8'h00, 8'hA7, 1, 8'h3C);
    vec[12] = mk(1, 1, 8'h50, 8'h11, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 8'h50, 8'h11, 8'h00, 1, 8'hA7);
    vec[13] = mk(0, 1, 8'h50, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h50, 8'h00, 8'h11, 0, 8'hA7);
    vec[14] = mk(0, 0, 8'h41, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h41, 8'h00, 8'h88, 0, 8'hA7);
    vec[15] = mk(0, 0, 8'h40, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h40, 8'h00, 8'h77, 0, 8'hA7);
    vec[16] = mk(0, 0, 8'h00, 8'h00, 1, 8'hFF, 0, 8'h00, 8'h00, 1, 0, 0, 8'hFF, 8'h00, 8'hE1, 0, 8'hA7);
    vec[17] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'hE1);

    pre_a[0] = 8'h10; pre_d[0] = 8'h3C;
    pre_a[1] = 8'h11; pre_d[1] = 8'h5A;
    pre_a[2] = 8'h12; pre_d[2] = 8'hC3;
    pre_a[3] = 8'h05; pre_d[3] = 8'hA7;
    pre_a[4] = 8'hFF; pre_d[4] = 8'hE1;

    // Preload RAM while held in reset
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      ld_en = 1'b1; ld_addr = pre_a[i]; ld_data = pre_d[i];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;

    // Reset blocks everything, even an active CPU store
    drive(1, 0, 8'h60, 8'h12, 1, 8'h10, 1, 8'h61, 8'h34);
    @(negedge clk);
    chk("rst_mem_we", 32'(bus.MEM_WE), 32'd0);
    chk("rst_p1_ready", 32'(bus.P1_READY), 32'd0);
    chk("rst_p2_ready", 32'(bus.P2_READY), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst_p1_rvalid", 32'(bus.P1_RVALID), 32'd0);
    chk("rst_p1_rdata", 32'(bus.P1_RDATA), 32'd0);
    chk("rst_starved", 32'(bus.STARVED), 32'd0);
    chk("rst_no_write", 32'(ram[8'h60]), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      drive(vec[i].we, vec[i].re, vec[i].caddr, vec[i].cwd, vec[i].v1, vec[i].a1,
            vec[i].v2, vec[i].a2, vec[i].d2);
      @(negedge clk);
      chk($sformatf("v%0d_p1_ready", i), 32'(bus.P1_READY), 32'(vec[i].r1));
      chk($sformatf("v%0d_p2_ready", i), 32'(bus.P2_READY), 32'(vec[i].r2));
      chk($sformatf("v%0d_mem_we", i), 32'(bus.MEM_WE), 32'(vec[i].mwe));
      chk($sformatf("v%0d_mem_addr", i), 32'(bus.MEM_ADDR), 32'(vec[i].madr));
      if (vec[i].mwe) chk($sformatf("v%0d_mem_wdata", i), 32'(bus.MEM_WDATA), 32'(vec[i].mwd));
      chk($sformatf("v%0d_cpu_rdata", i), 32'(bus.CPU_RDATA), 32'(vec[i].crd));
      chk($sformatf("v%0d_p1_rvalid", i), 32'(bus.P1_RVALID), 32'(vec[i].rv));
      chk($sformatf("v%0d_p1_rdata", i), 32'(bus.P1_RDATA), 32'(vec[i].rd));
      $display("vec %0d: mem_addr=%0h we=%0b rdy=%0b%0b rvalid=%0b rdata=%0h",
               i, bus.MEM_ADDR, bus.MEM_WE, bus.P2_READY, bus.P1_READY,
               bus.P1_RVALID, bus.P1_RDATA);
      @(posedge clk); #1;
    end

    // P1 blocked by continuous CPU loads until the starvation flag sets
    drive(0, 1, 8'h00, 8'h00, 1, 8'h10, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("starve_blocked_ready", 32'(bus.P1_READY), 32'd0);
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (i == 63) chk("starve_before_limit", 32'(bus.STARVED), 32'd0);
      if (i == 64) chk("starve_at_limit", 32'(bus.STARVED), 32'd1);
    end
    drive(0, 0, 8'h00, 8'h00, 1, 8'h10, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("starve_served_ready", 32'(bus.P1_READY), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("starve_served_rvalid", 32'(bus.P1_RVALID), 32'd1);
    chk("starve_served_rdata", 32'(bus.P1_RDATA), 32'h3C);
    repeat (3) @(posedge clk);
    #1;
    chk("starve_sticky", 32'(bus.STARVED), 32'd1);
    $display("starvation: STARVED=%0b", bus.STARVED);

    // Reset arriving in what would be a P1 fire cycle
    rst = 1'b1;
    drive(1, 0, 8'h60, 8'h12, 1, 8'h05, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("midrst_p1_ready", 32'(bus.P1_READY), 32'd0);
    chk("midrst_mem_we", 32'(bus.MEM_WE), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("midrst_rvalid", 32'(bus.P1_RVALID), 32'd0);
    chk("midrst_rdata", 32'(bus.P1_RDATA), 32'd0);
    chk("midrst_starved", 32'(bus.STARVED), 32'd0);
    chk("midrst_no_write", 32'(ram[8'h60]), 32'd0);
    $display("mid-reset: rvalid=%0b starved=%0b", bus.P1_RVALID, bus.STARVED);
    @(posedge clk); #1;

    // First tie after reset goes to P1, then P2 is served
    drive(0, 0, 8'h00, 8'h00, 1, 8'h05, 1, 8'h70, 8'h33);
    @(negedge clk);
    chk("tie_p1_ready", 32'(bus.P1_READY), 32'd1);
    chk("tie_p2_ready", 32'(bus.P2_READY), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h70, 8'h33);
    @(negedge clk);
    chk("tie2_p2_ready", 32'(bus.P2_READY), 32'd1);
    chk("tie2_mem_we", 32'(bus.MEM_WE), 32'd1);
    chk("tie2_rvalid", 32'(bus.P1_RVALID), 32'd1);
    chk("tie2_rdata", 32'(bus.P1_RDATA), 32'hA7);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("tie2_p2_write", 32'(ram[8'h70]), 32'h33);
    $display("tie: ram[70]=%0h", ram[8'h70]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
